diag_record_serializer: RTL and testbench

Buffers diagnostic records (error kind, source position, span length) raised by the checker stage and emits each one as a fixed 6-byte framed stream for the host-side message formatter. It sits directly downstream of the diagnostics producer, which decodes each error condition into one record. It provides elastic buffering, overflow detection and a saturating error count.

---
 rtl/diag_record_serializer.sv | 192 +++++++++++++++++++
 tb/tb_diag_record_serializer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diag_record_serializer.sv
// diag_record_serializer
// Buffers diagnostic records {code, pos, len} in a small FIFO and emits each
// one as a 6-byte frame: D1, code, pos_h, pos_l, len_h, len_l.
// Tracks a sticky overflow flag and a saturating count of stored records.
// Optional feature macro: DIAG_DEDUP_EN. When defined, a record identical to
// the last stored one is still handshaken but dropped and not counted.
module diag_record_serializer #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [CODE_W-1:0]        i_in_code,
  input  logic [15:0]              i_in_pos,
  input  logic [15:0]              i_in_len,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [7:0]               o_out_data,
  output logic                     o_out_last,
  output logic [15:0]              o_err_count,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = CODE_W + 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CODE,
    S_POS_H,
    S_POS_L,
    S_LEN_H,
    S_LEN_L
  } state_t;

  logic [RW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [RW-1:0] r_frame;
  state_t        r_state;
  logic          r_out_valid;
  logic          r_out_last;
  logic [15:0]   r_err_count;
  logic          r_overflow;

  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic [RW-1:0] w_in_rec;
  logic          w_accept;
  logic          w_dup;
  logic          w_push;
  logic          w_out_fire;
  logic          w_pop;
  logic [7:0]    w_code_byte;
  logic [7:0]    w_out_data;

  assign w_level    = r_wptr - r_rptr;
  assign w_full     = (w_level == (AW+1)'(DEPTH));
  assign w_empty    = (r_wptr == r_rptr);
  assign w_in_rec   = {i_in_code, i_in_pos, i_in_len};
  assign w_accept   = i_in_valid & ~w_full;
  assign w_push     = w_accept & ~w_dup;
  assign w_out_fire = r_out_valid & i_out_ready;
  assign w_pop      = ~w_empty & ((r_state == S_IDLE) |
                                  ((r_state == S_LEN_L) & w_out_fire));

`ifdef DIAG_DEDUP_EN
  logic          r_last_valid;
  logic [RW-1:0] r_last_rec;

  assign w_dup = r_last_valid & (r_last_rec == w_in_rec);

  // Remember the most recently stored record so repeats can be dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_valid <= 1'b0;
      r_last_rec   <= '0;
    end else if (w_push) begin
      r_last_valid <= 1'b1;
      r_last_rec   <= w_in_rec;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // Record storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_in_rec;
    end
  end

  // Wrapping pointers with an extra bit to distinguish full from empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Sticky overflow flag and saturating stored-record counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (i_in_valid & w_full) r_overflow <= 1'b1;
      if (w_push && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
    end
  end

  // Frame FSM: loads the FIFO head and walks the six bytes on each handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_frame     <= r_mem[r_rptr[AW-1:0]];
            r_state     <= S_HDR;
            r_out_valid <= 1'b1;
          end
        end
        S_HDR:   if (w_out_fire) r_state <= S_CODE;
        S_CODE:  if (w_out_fire) r_state <= S_POS_H;
        S_POS_H: if (w_out_fire) r_state <= S_POS_L;
        S_POS_L: if (w_out_fire) r_state <= S_LEN_H;
        S_LEN_H: begin
          if (w_out_fire) begin
            r_state    <= S_LEN_L;
            r_out_last <= 1'b1;
          end
        end
        S_LEN_L: begin
          if (w_out_fire) begin
            r_out_last <= 1'b0;
            if (w_pop) begin
              r_frame <= r_mem[r_rptr[AW-1:0]];
              r_state <= S_HDR;
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign w_code_byte = 8'(r_frame[RW-1:32]);

  // Select the current frame byte from the held frame register
  always_comb begin
    w_out_data = 8'h00;
    case (r_state)
      S_HDR:   w_out_data = 8'hD1;
      S_CODE:  w_out_data = w_code_byte;
      S_POS_H: w_out_data = r_frame[31:24];
      S_POS_L: w_out_data = r_frame[23:16];
      S_LEN_H: w_out_data = r_frame[15:8];
      S_LEN_L: w_out_data = r_frame[7:0];
      default: w_out_data = 8'h00;
    endcase
  end

  assign o_in_ready   = ~w_full;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = w_out_data;
  assign o_out_last   = r_out_last;
  assign o_err_count  = r_err_count;
  assign o_overflow   = r_overflow;
  assign o_fifo_level = w_level;

endmodule

// File: tb/tb_diag_record_serializer.sv
// Self-checking bench for diag_record_serializer.
// A queue-based reference model turns every stored record into its six
// expected bytes; a collector records every byte handshaken at the output.
module tb_diag_record_serializer;

  localparam int DEPTH  = 8;
  localparam int CODE_W = 5;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CODE_W-1:0] in_code = '0;
  logic [15:0]       in_pos = '0;
  logic [15:0]       in_len = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        out_data;
  logic              out_last;
  logic [15:0]       err_count;
  logic              overflow;
  logic [LW-1:0]     fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0] got_q[$];
  int         got_cyc[$];

  logic [7:0]         exp_q[$];
  int                 model_err;
  logic               model_last_valid;
  logic [CODE_W+31:0] model_last;

  diag_record_serializer #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_code    (in_code),
    .i_in_pos     (in_pos),
    .i_in_len     (in_len),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_last   (out_last),
    .o_err_count  (err_count),
    .o_overflow   (overflow),
    .o_fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Collect every output byte taken by the consumer, tagged with its edge index
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      got_cyc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  // Reference model: a stored record becomes six bytes and one count
  task automatic model_store(input logic [CODE_W-1:0] c, input logic [15:0] p,
                             input logic [15:0] l);
`ifdef DIAG_DEDUP_EN
    if (model_last_valid && (model_last == {c, p, l})) return;
    model_last_valid = 1'b1;
    model_last       = {c, p, l};
`endif
    exp_q.push_back(8'hD1);
    exp_q.push_back(8'(c));
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    if (model_err < 65535) model_err++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    model_err        = 0;
    model_last_valid = 1'b0;
    model_last       = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Offer one record and hold it until the handshake edge; called at a negedge
  task automatic send_record(input logic [CODE_W-1:0] c, input logic [15:0] p,
                             input logic [15:0] l, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_code  = c;
    in_pos   = p;
    in_len   = l;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        model_store(c, p, l);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int t = 0; t < limit; t++) begin
      if ((got_q.size() >= exp_q.size()) && !out_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("[TB] FAIL reset in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("[TB] FAIL reset out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00)    begin errors++; $display("[TB] FAIL reset out_data got=%h exp=00", out_data); end
    checks++; if (out_last !== 1'b0)     begin errors++; $display("[TB] FAIL reset out_last got=%b exp=0", out_last); end
    checks++; if (err_count !== 16'h0)   begin errors++; $display("[TB] FAIL reset err_count got=%h exp=0", err_count); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("[TB] FAIL reset overflow got=%b exp=0", overflow); end
    checks++; if (fifo_level !== '0)     begin errors++; $display("[TB] FAIL reset fifo_level got=%0d exp=0", fifo_level); end
    apply_reset();
  endtask

  task automatic test_single();
    bit ok;
    int acc;
    logic [8:0] e;
    apply_reset();
    out_ready = 1'b1;
    acc = cyc;
    send_record(5'd2, 16'h0123, 16'h0004, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single accept got=0 exp=1"); end
    drain(50);
    checks++; if (got_q.size() != 6) begin errors++; $display("[TB] FAIL single count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      e = {(i == 5), exp_q[i]};
      checks++; if (got_q[i] !== e) begin errors++; $display("[TB] FAIL single byte[%0d] got=%h exp=%h", i, got_q[i], e); end
      checks++; if (got_cyc[i] != acc + 2 + i) begin errors++; $display("[TB] FAIL single timing[%0d] got=%0d exp=%0d", i, got_cyc[i], acc + 2 + i); end
    end
    checks++; if (err_count !== 16'd1) begin errors++; $display("[TB] FAIL single err_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [8:0] e;
    apply_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      send_record(CODE_W'($urandom_range(0, 23)), 16'($urandom), 16'($urandom), ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b accept[%0d] got=0 exp=1", r); end
    end
    drain(100);
    checks++; if (got_q.size() != 18) begin errors++; $display("[TB] FAIL b2b count got=%0d exp=18", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = {((i % 6) == 5), exp_q[i]};
      checks++; if (got_q[i] !== e) begin errors++; $display("[TB] FAIL b2b byte[%0d] got=%h exp=%h", i, got_q[i], e); end
      checks++; if (got_cyc[i] != got_cyc[0] + i) begin errors++; $display("[TB] FAIL b2b gap[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    checks++; if (fifo_level !== '0) begin errors++; $display("[TB] FAIL b2b level got=%0d exp=0", fifo_level); end
    checks++; if (err_count !== 16'(model_err)) begin errors++; $display("[TB] FAIL b2b err_count got=%0d exp=%0d", err_count, model_err); end
  endtask

  // With the consumer stalled, DEPTH records fill the FIFO and one more sits in the frame register
  task automatic test_overflow();
    logic [CODE_W-1:0] c;
    logic [15:0] l;
    logic [8:0] e;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      c = CODE_W'($urandom_range(0, 23));
      l = 16'($urandom);
      in_valid = 1'b1;
      in_code  = c;
      in_pos   = 16'(i);
      in_len   = l;
      if (i < DEPTH + 1) model_store(c, 16'(i), l);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf in_ready got=%b exp=0", in_ready); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf flag got=%b exp=1", overflow); end
    checks++; if (err_count !== 16'(DEPTH + 1)) begin errors++; $display("[TB] FAIL ovf err_count got=%0d exp=%0d", err_count, DEPTH + 1); end
    checks++; if (fifo_level !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL ovf level got=%0d exp=%0d", fifo_level, DEPTH); end
    out_ready = 1'b1;
    drain(200);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL ovf count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = {((i % 6) == 5), exp_q[i]};
      checks++; if (got_q[i] !== e) begin errors++; $display("[TB] FAIL ovf byte[%0d] got=%h exp=%h", i, got_q[i], e); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_random_stall();
    bit prod_done;
    bit ok;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [8:0] e;
    apply_reset();
    prod_done  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    fork
      begin
        for (int r = 0; r < 20; r++) begin
          send_record(CODE_W'($urandom_range(0, 23)), 16'($urandom), 16'($urandom), ok);
          checks++; if (!ok) begin errors++; $display("[TB] FAIL stall accept[%0d] got=0 exp=1", r); end
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        prod_done = 1'b1;
      end
      begin
        for (int t = 0; t < 3000; t++) begin
          if (prev_stall) begin
            checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin
              errors++; $display("[TB] FAIL stall hold got=%b/%h exp=1/%h", out_valid, out_data, prev_data);
            end
          end
          if (prod_done && (got_q.size() >= exp_q.size()) && !out_valid) break;
          out_ready  = 1'($urandom_range(0, 1));
          prev_stall = out_valid && !out_ready;
          prev_data  = out_data;
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    checks++; if (got_q.size() != 120) begin errors++; $display("[TB] FAIL stall count got=%0d exp=120", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = {((i % 6) == 5), exp_q[i]};
      checks++; if (got_q[i] !== e) begin errors++; $display("[TB] FAIL stall byte[%0d] got=%h exp=%h", i, got_q[i], e); end
    end
    checks++; if (err_count !== 16'(model_err)) begin errors++; $display("[TB] FAIL stall err_count got=%0d exp=%0d", err_count, model_err); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    apply_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      send_record(CODE_W'(r + 1), 16'h1000 + 16'(r), 16'h0020 + 16'(r), ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst accept[%0d] got=0 exp=1", r); end
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_data !== exp_q[3]) begin errors++; $display("[TB] FAIL midrst pos_l got=%h exp=%h", out_data, exp_q[3]); end
    checks++; if (got_q.size() != 3) begin errors++; $display("[TB] FAIL midrst pre count got=%0d exp=3", got_q.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("[TB] FAIL midrst in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL midrst out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00)  begin errors++; $display("[TB] FAIL midrst out_data got=%h exp=00", out_data); end
    checks++; if (out_last !== 1'b0)   begin errors++; $display("[TB] FAIL midrst out_last got=%b exp=0", out_last); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("[TB] FAIL midrst err_count got=%h exp=0", err_count); end
    checks++; if (fifo_level !== '0)   begin errors++; $display("[TB] FAIL midrst level got=%0d exp=0", fifo_level); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("[TB] FAIL midrst residual got=%0d exp=0", got_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_dedup();
    bit ok;
    int exp_bytes;
    logic [8:0] e;
`ifdef DIAG_DEDUP_EN
    exp_bytes = 12;
`else
    exp_bytes = 18;
`endif
    apply_reset();
    out_ready = 1'b1;
    send_record(5'd7, 16'hBEEF, 16'h0010, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL dedup accept[0] got=0 exp=1"); end
    send_record(5'd7, 16'hBEEF, 16'h0010, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL dedup accept[1] got=0 exp=1"); end
    send_record(5'd9, 16'hBEEF, 16'h0010, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL dedup accept[2] got=0 exp=1"); end
    drain(100);
    checks++; if (got_q.size() != exp_bytes) begin errors++; $display("[TB] FAIL dedup count got=%0d exp=%0d", got_q.size(), exp_bytes); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = {((i % 6) == 5), exp_q[i]};
      checks++; if (got_q[i] !== e) begin errors++; $display("[TB] FAIL dedup byte[%0d] got=%h exp=%h", i, got_q[i], e); end
    end
    checks++; if (err_count !== 16'(exp_bytes / 6)) begin errors++; $display("[TB] FAIL dedup err_count got=%0d exp=%0d", err_count, exp_bytes / 6); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_random_stall();
    test_mid_reset();
    test_dedup();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
